// File: rtl/shift_ou_pipelined.sv
// Pipelined shift operating unit: SLL / SRL / SRA (+ optional ROR) over a
// log-shifter split across PIPE_STAGES registers, feeding an output FIFO.
// Optional feature macro: SHIFT_OU_ROTATE_EN (mode 11 = ROR; else mode 11 = SRL).
// The LSQ port set is tied off; this unit never issues memory traffic.

// Combinational slice of the log shifter: applies levels [LO, LO+NLV).
module shift_ou_stage #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int LO      = 0,
  parameter int NLV     = 1
) (
  input  logic [DATA_W-1:0]  din,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         mode,
  output logic [DATA_W-1:0]  dout
);
  // Each level shifts by 2^j when shamt bit j is set; all modes compose.
  always_comb begin
    int s;
    s    = 0;
    dout = din;
    for (int j = LO; j < LO + NLV; j++) begin
      s = 1 << j;
      if (shamt[j]) begin
        unique case (mode)
          2'b00: dout = dout << s;
          2'b10: dout = DATA_W'($signed(dout) >>> s);
`ifdef SHIFT_OU_ROTATE_EN
          2'b11: dout = (dout >> s) | (dout << (DATA_W - s));
`endif
          default: dout = dout >> s;
        endcase
      end
    end
  end
endmodule

module shift_ou_pipelined #(
  parameter int DATA_W         = 32,
  parameter int SHAMT_W        = $clog2(DATA_W),
  parameter int PIPE_STAGES    = 2,
  parameter int OUT_FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic              data_valid_in1,
  input  logic              data_valid_in2,
  input  logic [1:0]        mode,
  output logic              data_in_ack1,
  output logic              data_in_ack2,
  output logic              uses_data_in1,
  output logic              uses_data_in2,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid_out,
  input  logic              data_out_ack,
  output logic [DATA_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic [2:0]        fn3,
  output logic              load,
  output logic              store,
  output logic              new_request,
  input  logic              lsq_full,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_complete
);
  localparam int NS    = PIPE_STAGES;
  localparam int LPS   = SHAMT_W / NS;
  localparam int L0    = LPS + SHAMT_W % NS;
  localparam int DEPTH = OUT_FIFO_DEPTH;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic [NS-1:0]                 vld_q, vld_d, in_vld, ready, adv;
  logic [NS-1:0][DATA_W-1:0]     dat_q, dat_d, stg_in, stg_out;
  logic [NS-1:0][SHAMT_W-1:0]    sh_q, sh_d, sh_in;
  logic [NS-1:0][1:0]            md_q, md_d, md_in;
  logic [DEPTH-1:0][DATA_W-1:0]  mem_q, mem_d;
  logic [PW-1:0]                 wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          accept, last_ok, push, pop, fifo_nz;

  // Per-stage operand source and shifter slice; shamt/mode ride with the data.
  for (genvar k = 0; k < NS; k++) begin : g_stg
    if (k == 0) begin : g_head
      assign stg_in[k] = data_in1;
      assign sh_in[k]  = data_in2[SHAMT_W-1:0];
      assign md_in[k]  = mode;
      assign in_vld[k] = accept;
    end else begin : g_body
      assign stg_in[k] = dat_q[k-1];
      assign sh_in[k]  = sh_q[k-1];
      assign md_in[k]  = md_q[k-1];
      assign in_vld[k] = adv[k-1];
    end
    shift_ou_stage #(
      .DATA_W(DATA_W), .SHAMT_W(SHAMT_W),
      .LO((k == 0) ? 0 : L0 + (k - 1) * LPS),
      .NLV((k == 0) ? L0 : LPS)
    ) u_stage (
      .din(stg_in[k]), .shamt(sh_in[k]), .mode(md_in[k]), .dout(stg_out[k])
    );
  end

  // Handshake: a stage is ready if it or any later stage has a hole, or the
  // tail can leave. Unrolled from vld_q so there is no comb chain on ready.
  always_comb begin
    fifo_nz = (cnt_q != '0);
    last_ok = (cnt_q != CW'(DEPTH)) | data_out_ack;
    for (int k = 0; k < NS; k++) begin
      ready[k] = last_ok;
      for (int j = k; j < NS; j++)
        if (!vld_q[j]) ready[k] = 1'b1;
    end
    for (int k = 0; k < NS - 1; k++) adv[k] = vld_q[k] & ready[k+1];
    adv[NS-1] = vld_q[NS-1] & last_ok;
    accept    = rst & data_valid_in1 & data_valid_in2 & ready[0];
  end

  // Stage registers load whenever ready; payload only moves with a valid.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    sh_d  = sh_q;
    md_d  = md_q;
    for (int k = 0; k < NS; k++) begin
      if (ready[k]) vld_d[k] = in_vld[k];
      if (ready[k] && in_vld[k]) begin
        dat_d[k] = stg_out[k];
        sh_d[k]  = sh_in[k];
        md_d[k]  = md_in[k];
      end
    end
  end

  // Output FIFO. The tail stage register acts as its fall-through slot: when
  // the FIFO is empty the tail is presented directly and, if taken, bypasses.
  always_comb begin
    pop   = data_out_ack & fifo_nz;
    push  = adv[NS-1] & ~(~fifo_nz & data_out_ack);
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = dat_q[NS-1];
      wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    end
    if (pop) rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // All state clears asynchronously; in-flight and buffered results are lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      dat_q <= '0;
      sh_q  <= '0;
      md_q  <= '0;
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      sh_q  <= sh_d;
      md_q  <= md_d;
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign data_in_ack1   = accept;
  assign data_in_ack2   = accept;
  assign uses_data_in1  = 1'b1;
  assign uses_data_in2  = 1'b1;
  assign data_valid_out = fifo_nz | vld_q[NS-1];
  assign data_out       = fifo_nz ? mem_q[rd_q] : (vld_q[NS-1] ? dat_q[NS-1] : '0);

  assign addr        = '0;
  assign data        = '0;
  assign fn3         = '0;
  assign load        = 1'b0;
  assign store       = 1'b0;
  assign new_request = 1'b0;

  logic unused_sink;
  assign unused_sink = ^{lsq_full, load_data, load_complete,
                         data_in2[DATA_W-1:SHAMT_W], sh_q[NS-1], md_q[NS-1]};
endmodule

// File: tb/tb_shift_ou_pipelined.sv
// Randomized + directed bench for shift_ou_pipelined (DATA_W=32, 2 stages, FIFO 2).
module tb_shift_ou_pipelined;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  data_in1, data_in2;
  logic          data_valid_in1, data_valid_in2;
  logic [1:0]    mode;
  logic          data_in_ack1, data_in_ack2, uses_data_in1, uses_data_in2;
  logic [W-1:0]  data_out;
  logic          data_valid_out, data_out_ack;
  logic [W-1:0]  addr, data;
  logic [2:0]    fn3;
  logic          load, store, new_request;
  logic          lsq_full = 1'b0;
  logic [W-1:0]  load_data = '0;
  logic          load_complete = 1'b0;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [W-1:0]  exp_q[$];
  bit            sb_en = 1'b0;

  always #5 clk = ~clk;

  shift_ou_pipelined #(.DATA_W(W), .PIPE_STAGES(2), .OUT_FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .data_in1(data_in1), .data_in2(data_in2),
    .data_valid_in1(data_valid_in1), .data_valid_in2(data_valid_in2),
    .mode(mode),
    .data_in_ack1(data_in_ack1), .data_in_ack2(data_in_ack2),
    .uses_data_in1(uses_data_in1), .uses_data_in2(uses_data_in2),
    .data_out(data_out), .data_valid_out(data_valid_out), .data_out_ack(data_out_ack),
    .addr(addr), .data(data), .fn3(fn3),
    .load(load), .store(store), .new_request(new_request),
    .lsq_full(lsq_full), .load_data(load_data), .load_complete(load_complete)
  );

  // Reference: whole shift at once from the arithmetic definition.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] m);
    int s;
    logic [W-1:0] r;
    s = int'(b % W);
    r = a;
    case (m)
      2'd0: r = a << s;
      2'd1: r = a >> s;
      2'd2: r = W'($signed(a) >>> s);
      default: begin
`ifdef SHIFT_OU_ROTATE_EN
        for (int i = 0; i < s; i++) r = {r[0], r[W-1:1]};
`else
        r = a >> s;
`endif
      end
    endcase
    return r;
  endfunction

  // Scoreboard: record accepted ops, check every presented result in order.
  always @(negedge clk) begin
    if (sb_en && rst) begin
      if (data_valid_out) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: data_out=%h with nothing outstanding", data_out);
        end else if (data_out !== exp_q[0]) begin
          n_fail++;
          $display("FAIL sb_data: got %h expected %h", data_out, exp_q[0]);
        end
        if (data_out_ack && exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (data_in_ack1 || data_in_ack2) begin
        n_tests++;
        if (data_in_ack1 !== data_in_ack2 || data_valid_in1 !== 1'b1 || data_valid_in2 !== 1'b1) begin
          n_fail++;
          $display("FAIL sb_ack: ack1=%b ack2=%b v1=%b v2=%b expected both acks with both valids",
                   data_in_ack1, data_in_ack2, data_valid_in1, data_valid_in2);
        end
        exp_q.push_back(ref_shift(data_in1, data_in2, mode));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    data_valid_in1 = 1'b0;
    data_valid_in2 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    data_in1 = 32'h1234_5678; data_in2 = 32'd3; mode = 2'd0;
    data_valid_in1 = 1'b1; data_valid_in2 = 1'b1; data_out_ack = 1'b0;
    step();
    n_tests++;
    if (data_valid_out !== 1'b0 || data_out !== '0) begin
      n_fail++;
      $display("FAIL reset_out: valid=%b data=%h expected 0/0", data_valid_out, data_out);
    end
    n_tests++;
    if (data_in_ack1 !== 1'b0 || data_in_ack2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ack: ack1=%b ack2=%b expected 0", data_in_ack1, data_in_ack2);
    end
    n_tests++;
    if ({addr, data, fn3, load, store, new_request} !== '0 || {uses_data_in1, uses_data_in2} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_tieoff: lsq=%h uses=%b%b expected 0 and 11",
               {addr, data, fn3, load, store, new_request}, uses_data_in1, uses_data_in2);
    end
    idle_inputs();
    exp_q.delete();
    rst = 1'b1;
    sb_en = 1'b1;
  endtask

  // Spec vectors; checks 2-cycle latency and mode change while in flight.
  task automatic test_directed();
    logic [W-1:0] va[4], vb[4], ve[4];
    logic [1:0]   vm[4];
    va[0] = 32'h8000_0010; vb[0] = 32'hFFFF_FFE4; vm[0] = 2'd2; ve[0] = 32'hF800_0001;
    va[1] = 32'h8000_0010; vb[1] = 32'h0000_0004; vm[1] = 2'd1; ve[1] = 32'h0800_0001;
    va[2] = 32'h0000_0001; vb[2] = 32'd31;        vm[2] = 2'd0; ve[2] = 32'h8000_0000;
    va[3] = 32'h0000_0001; vb[3] = 32'd1;         vm[3] = 2'd3;
`ifdef SHIFT_OU_ROTATE_EN
    ve[3] = 32'h8000_0000;
`else
    ve[3] = 32'h0000_0000;
`endif
    data_out_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in1 = va[i]; data_in2 = vb[i]; mode = vm[i];
      data_valid_in1 = 1'b1; data_valid_in2 = 1'b1;
      @(negedge clk);
      n_tests++;
      if (data_in_ack1 !== 1'b1) begin
        n_fail++;
        $display("FAIL dir_ack[%0d]: got %b expected 1", i, data_in_ack1);
      end
      step();
      idle_inputs();
      mode = ~vm[i];
      @(negedge clk);
      n_tests++;
      if (data_valid_out !== 1'b0) begin
        n_fail++;
        $display("FAIL dir_early[%0d]: valid_out=%b expected 0 one cycle after accept", i, data_valid_out);
      end
      step();
      @(negedge clk);
      n_tests++;
      if (data_valid_out !== 1'b1 || data_out !== ve[i]) begin
        n_fail++;
        $display("FAIL dir_result[%0d]: valid=%b data=%h expected 1/%h", i, data_valid_out, data_out, ve[i]);
      end
      step();
    end
  endtask

  task automatic test_stream();
    int first = -1, last = -1, cnt = 0;
    data_out_ack = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c < 8) begin
        data_in1 = $urandom; data_in2 = $urandom; mode = 2'($urandom_range(0, 3));
        data_valid_in1 = 1'b1; data_valid_in2 = 1'b1;
      end else idle_inputs();
      @(negedge clk);
      if (c < 8) begin
        n_tests++;
        if (data_in_ack1 !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_ack[%0d]: got %b expected 1", c, data_in_ack1);
        end
      end
      if (data_valid_out === 1'b1) begin
        cnt++;
        if (first < 0) first = c;
        last = c;
      end
      step();
    end
    n_tests++;
    if (cnt != 8 || last - first != 7) begin
      n_fail++;
      $display("FAIL stream_rate: %0d results over span %0d, expected 8 over 7", cnt, last - first);
    end
  endtask

  task automatic test_backpressure();
    int n_acc = 0, n_out = 0;
    logic [W-1:0] held;
    bit took;
    data_out_ack = 1'b0;
    data_in1 = $urandom; data_in2 = $urandom; mode = 2'($urandom_range(0, 3));
    data_valid_in1 = 1'b1; data_valid_in2 = 1'b1;
    held = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      took = data_in_ack1;
      if (took) n_acc++;
      if (c == 4) held = data_out;
      if (c == 7) begin
        n_tests++;
        if (data_valid_out !== 1'b1 || data_out !== held) begin
          n_fail++;
          $display("FAIL bp_stable: valid=%b data=%h expected 1/%h", data_valid_out, data_out, held);
        end
      end
      step();
      if (took) begin
        data_in1 = $urandom; data_in2 = $urandom; mode = 2'($urandom_range(0, 3));
      end
    end
    idle_inputs();
    n_tests++;
    if (n_acc != 4) begin
      n_fail++;
      $display("FAIL bp_accepts: got %0d expected 4", n_acc);
    end
    data_out_ack = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (data_valid_out === 1'b1) n_out++;
      step();
    end
    n_tests++;
    if (n_out != 4 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_drain: got %0d results, %0d outstanding; expected 4, 0", n_out, exp_q.size());
    end
  endtask

  task automatic test_partial_valid();
    data_out_ack = 1'b1;
    data_in1 = $urandom; data_in2 = $urandom; mode = 2'd1;
    data_valid_in1 = 1'b1; data_valid_in2 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++;
      if (data_in_ack1 !== 1'b0 || data_in_ack2 !== 1'b0 || data_valid_out !== 1'b0) begin
        n_fail++;
        $display("FAIL partial_hold[%0d]: ack=%b%b valid_out=%b expected 00/0",
                 c, data_in_ack1, data_in_ack2, data_valid_out);
      end
      step();
    end
    data_valid_in2 = 1'b1;
    @(negedge clk);
    n_tests++;
    if (data_in_ack1 !== 1'b1 || data_in_ack2 !== 1'b1) begin
      n_fail++;
      $display("FAIL partial_ack: ack=%b%b expected 11", data_in_ack1, data_in_ack2);
    end
    step();
    idle_inputs();
    repeat (4) step();
  endtask

  task automatic test_mode_switch();
    logic [W-1:0] got[2];
    int n = 0;
    data_out_ack = 1'b1;
    data_in1 = 32'h8000_F00F; data_in2 = 32'd4;
    data_valid_in1 = 1'b1; data_valid_in2 = 1'b1;
    mode = 2'd0;
    step();
    mode = 2'd2;
    step();
    idle_inputs();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (data_valid_out === 1'b1 && n < 2) begin
        got[n] = data_out;
        n++;
      end
      step();
    end
    n_tests++;
    if (n != 2 || got[0] !== ref_shift(32'h8000_F00F, 32'd4, 2'd0)
               || got[1] !== ref_shift(32'h8000_F00F, 32'd4, 2'd2)) begin
      n_fail++;
      $display("FAIL mode_switch: n=%0d got %h,%h expected %h,%h", n, got[0], got[1],
               ref_shift(32'h8000_F00F, 32'd4, 2'd0), ref_shift(32'h8000_F00F, 32'd4, 2'd2));
    end
  endtask

  task automatic test_reset_midflight();
    data_out_ack = 1'b0;
    data_valid_in1 = 1'b1; data_valid_in2 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      data_in1 = $urandom; data_in2 = $urandom; mode = 2'($urandom_range(0, 3));
      step();
    end
    idle_inputs();
    @(negedge clk);
    n_tests++;
    if (data_valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: valid_out=%b expected 1 with ops in flight", data_valid_out);
    end
    #1;
    sb_en = 1'b0;
    rst = 1'b0;
    #1;
    n_tests++;
    if (data_valid_out !== 1'b0 || data_out !== '0) begin
      n_fail++;
      $display("FAIL rst_async: valid=%b data=%h expected 0/0 before any edge", data_valid_out, data_out);
    end
    step();
    step();
    exp_q.delete();
    rst = 1'b1;
    sb_en = 1'b1;
    data_out_ack = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_tests++;
      if (data_valid_out !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_stale[%0d]: valid_out=%b data=%h expected no result", c, data_valid_out, data_out);
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] b;
    int guard = 0;
    for (int c = 0; c < 300; c++) begin
      data_in1 = $urandom;
      b = $urandom;
      if ($urandom_range(0, 4) == 0) b[4:0] = 5'd0;
      else if ($urandom_range(0, 4) == 0) b[4:0] = 5'd31;
      data_in2 = b;
      mode = 2'($urandom_range(0, 3));
      data_valid_in1 = ($urandom_range(0, 3) != 0);
      data_valid_in2 = ($urandom_range(0, 3) != 0);
      data_out_ack   = ($urandom_range(0, 2) != 0);
      step();
    end
    idle_inputs();
    data_out_ack = 1'b1;
    while (exp_q.size() != 0 && guard < 20) begin
      step();
      guard++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_drain: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_stream();
    test_backpressure();
    test_partial_valid();
    test_mode_switch();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
